// File: rtl/dds_ctrl_pkg.sv
// DDS front-panel controller: shared constants, step table and key FSM states.
// Imported by the key scanner and the configuration top.
package dds_ctrl_pkg;

   localparam logic [1:0] WAVE_SINE   = 2'd0;
   localparam logic [1:0] WAVE_SQUARE = 2'd1;
   localparam logic [1:0] WAVE_TRI    = 2'd2;
   localparam logic [1:0] WAVE_SAW    = 2'd3;

   typedef enum logic [2:0] {
      IDLE,
      PRESS_DB,
      HELD,
      REPEAT,
      REL_DB
   } key_state_t;

   // Step table in FCW units: 100 Hz, 1 kHz, 10 kHz, 100 kHz at 50 MHz.
   function automatic logic [31:0] step_val(input logic [1:0] idx);
      logic [31:0] v;
      case (idx)
         2'd0:    v = 32'd8590;
         2'd1:    v = 32'd85900;
         2'd2:    v = 32'd859000;
         default: v = 32'd8590000;
      endcase
      return v;
   endfunction

   function automatic int unsigned cnt_width(
      input int unsigned a,
      input int unsigned b,
      input int unsigned c
   );
      int unsigned m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      return $clog2(m + 1);
   endfunction

endpackage

// File: rtl/dds_key_scan.sv
// One push-button: 2-FF synchroniser, counter debounce and optional
// auto-repeat, producing a registered one-cycle press event.
module dds_key_scan
   import dds_ctrl_pkg::*;
#(
   parameter bit          REPEAT_EN    = 1'b0,
   parameter int unsigned DEBOUNCE_CYC = 1000000,
   parameter int unsigned HOLD_CYC     = 25000000,
   parameter int unsigned REPEAT_CYC   = 5000000
)(
   input  logic CLK,
   input  logic RSTn,
   input  logic Key_n,
   output logic Key_Ev
);

   localparam int unsigned CNT_W =
      cnt_width(DEBOUNCE_CYC, HOLD_CYC, REPEAT_CYC);
   localparam logic [CNT_W-1:0] DB_END  = CNT_W'(DEBOUNCE_CYC - 1);
   localparam logic [CNT_W-1:0] HLD_END = CNT_W'(HOLD_CYC - 1);
   localparam logic [CNT_W-1:0] REP_END = CNT_W'(REPEAT_CYC - 1);

   logic [1:0]       sync;
   logic             level;
   logic [CNT_W-1:0] cnt;
   logic             from_rep;
   key_state_t       state;

   assign level = sync[1];

   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         sync     <= 2'b11;
         state    <= IDLE;
         cnt      <= '0;
         from_rep <= 1'b0;
         Key_Ev   <= 1'b0;
      end else begin
         sync   <= {sync[0], Key_n};
         Key_Ev <= 1'b0;
         case (state)
            IDLE: begin
               if (!level) begin
                  state <= PRESS_DB;
                  cnt   <= '0;
               end
            end
            PRESS_DB: begin
               if (level) begin
                  state <= IDLE;
                  cnt   <= '0;
               end else if (cnt == DB_END) begin
                  state  <= HELD;
                  cnt    <= '0;
                  Key_Ev <= 1'b1;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            HELD: begin
               if (level) begin
                  state    <= REL_DB;
                  cnt      <= '0;
                  from_rep <= 1'b0;
               end else if (REPEAT_EN && cnt == HLD_END) begin
                  state  <= REPEAT;
                  cnt    <= '0;
                  Key_Ev <= 1'b1;
               end else if (REPEAT_EN) begin
                  cnt <= cnt + 1'b1;
               end
            end
            REPEAT: begin
               if (level) begin
                  state    <= REL_DB;
                  cnt      <= '0;
                  from_rep <= 1'b1;
               end else if (cnt == REP_END) begin
                  cnt    <= '0;
                  Key_Ev <= 1'b1;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            REL_DB: begin
               // A bounce during release resumes holding silently.
               if (!level) begin
                  state <= from_rep ? REPEAT : HELD;
                  cnt   <= '0;
               end else if (cnt == DB_END) begin
                  state <= IDLE;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: begin
               state <= IDLE;
               cnt   <= '0;
            end
         endcase
      end
   end

endmodule

// File: rtl/dds_key_ctrl.sv
// DDS front-panel top: four key scanners feeding the FCW, waveform and
// step registers with saturating frequency arithmetic.
module dds_key_ctrl
   import dds_ctrl_pkg::*;
#(
   parameter int unsigned FCW_W        = 32,
   parameter int unsigned FCW_INIT     = 85899,
   parameter int unsigned FCW_MIN      = 8590,
   parameter int unsigned FCW_MAX      = 858993459,
   parameter int unsigned DEBOUNCE_CYC = 1000000,
   parameter int unsigned HOLD_CYC     = 25000000,
   parameter int unsigned REPEAT_CYC   = 5000000
)(
   input  logic             CLK,
   input  logic             RSTn,
   input  logic             Key_Up_n,
   input  logic             Key_Dn_n,
   input  logic             Key_Step_n,
   input  logic             Key_Wave_n,
   output logic [FCW_W-1:0] FCW,
   output logic [1:0]       Wave_Sel,
   output logic [1:0]       Step_Sel,
   output logic             Cfg_Update,
   output logic             Limit_Hit
);

   localparam int unsigned XW = FCW_W + 1;
   localparam logic [FCW_W:0] MAX_X = XW'(FCW_MAX);
   localparam logic [FCW_W:0] MIN_X = XW'(FCW_MIN);
   localparam logic [FCW_W-1:0] INIT_V = FCW_W'(FCW_INIT);

   logic [3:0] key_n;
   logic [3:0] ev;
   logic       ev_up, ev_dn, ev_step, ev_wave;

   assign key_n = {Key_Wave_n, Key_Step_n, Key_Dn_n, Key_Up_n};
   assign {ev_wave, ev_step, ev_dn, ev_up} = ev;

   for (genvar i = 0; i < 4; i++) begin : g_key
      dds_key_scan #(
         .REPEAT_EN    (i < 2),
         .DEBOUNCE_CYC (DEBOUNCE_CYC),
         .HOLD_CYC     (HOLD_CYC),
         .REPEAT_CYC   (REPEAT_CYC)
      ) u_scan (
         .CLK    (CLK),
         .RSTn   (RSTn),
         .Key_n  (key_n[i]),
         .Key_Ev (ev[i])
      );
   end

   logic [FCW_W:0]   step_x, fcw_x, sum_x, lo_x;
   logic [FCW_W-1:0] fcw_nxt;
   logic             lim_nxt;

   assign step_x = XW'(step_val(Step_Sel));
   assign fcw_x  = {1'b0, FCW};
   assign sum_x  = fcw_x + step_x;
   assign lo_x   = MIN_X + step_x;

   // Up and Dn together cancel; the old Step_Sel is used this cycle.
   always_comb begin
      fcw_nxt = FCW;
      lim_nxt = 1'b0;
      if (ev_up && !ev_dn) begin
         if (sum_x > MAX_X) begin
            fcw_nxt = MAX_X[FCW_W-1:0];
            lim_nxt = 1'b1;
         end else begin
            fcw_nxt = sum_x[FCW_W-1:0];
         end
      end else if (ev_dn && !ev_up) begin
         if (fcw_x < lo_x) begin
            fcw_nxt = MIN_X[FCW_W-1:0];
            lim_nxt = 1'b1;
         end else begin
            fcw_nxt = FCW - step_x[FCW_W-1:0];
         end
      end
   end

   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         FCW        <= INIT_V;
         Wave_Sel   <= WAVE_SINE;
         Step_Sel   <= 2'd0;
         Cfg_Update <= 1'b0;
         Limit_Hit  <= 1'b0;
      end else begin
         FCW        <= fcw_nxt;
         Limit_Hit  <= lim_nxt;
         Cfg_Update <= ev_wave || (fcw_nxt != FCW);
         if (ev_wave) Wave_Sel <= Wave_Sel + 2'd1;
         if (ev_step) Step_Sel <= Step_Sel + 2'd1;
      end
   end

endmodule

// File: tb/tb_dds_key_ctrl.sv
// Directed bench for dds_key_ctrl with short debounce/hold/repeat times.
// Pulse outputs are tallied per step and compared with hand-derived values.
module tb_dds_key_ctrl;

   localparam logic [3:0] K_UP   = 4'b0001;
   localparam logic [3:0] K_DN   = 4'b0010;
   localparam logic [3:0] K_STEP = 4'b0100;
   localparam logic [3:0] K_WAVE = 4'b1000;

   logic        CLK = 1'b0;
   logic        RSTn = 1'b0;
   logic [3:0]  keys_n = 4'hF;
   logic [31:0] FCW;
   logic [1:0]  Wave_Sel, Step_Sel;
   logic        Cfg_Update, Limit_Hit;

   int checks = 0;
   int errors = 0;
   int upd_cnt = 0;
   int lim_cnt = 0;
   int n;

   dds_key_ctrl #(
      .FCW_W        (32),
      .FCW_INIT     (85899),
      .FCW_MIN      (8590),
      .FCW_MAX      (100000),
      .DEBOUNCE_CYC (4),
      .HOLD_CYC     (20),
      .REPEAT_CYC   (8)
   ) dut (
      .CLK        (CLK),
      .RSTn       (RSTn),
      .Key_Up_n   (keys_n[0]),
      .Key_Dn_n   (keys_n[1]),
      .Key_Step_n (keys_n[2]),
      .Key_Wave_n (keys_n[3]),
      .FCW        (FCW),
      .Wave_Sel   (Wave_Sel),
      .Step_Sel   (Step_Sel),
      .Cfg_Update (Cfg_Update),
      .Limit_Hit  (Limit_Hit)
   );

   always #5 CLK = ~CLK;

   always @(negedge CLK) begin
      if (Cfg_Update) upd_cnt++;
      if (Limit_Hit) lim_cnt++;
   end

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic clr();
      upd_cnt = 0;
      lim_cnt = 0;
   endtask

   task automatic press(input logic [3:0] m, input int cyc);
      keys_n = ~m;
      repeat (cyc) tick();
      keys_n = 4'hF;
      repeat (12) tick();
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   initial begin
      repeat (3) tick();
      chk("rst_fcw", FCW, 85899);
      chk("rst_wave", 32'(Wave_Sel), 0);
      chk("rst_step", 32'(Step_Sel), 0);
      chk("rst_upd", 32'(Cfg_Update), 0);
      chk("rst_lim", 32'(Limit_Hit), 0);
      RSTn = 1'b1;
      repeat (2) tick();

      clr();
      for (int i = 0; i < 2; i++) begin
         keys_n = ~K_UP;
         repeat (2) tick();
         keys_n = 4'hF;
         repeat (2) tick();
      end
      press(K_UP, 10);
      chk("bounce_fcw", FCW, 94489);
      chk("bounce_upd", upd_cnt, 1);
      chk("bounce_lim", lim_cnt, 0);

      clr();
      press(K_UP, 60);
      chk("rep_fcw", FCW, 100000);
      chk("rep_upd", upd_cnt, 1);
      chk("rep_lim", lim_cnt, 6);

      RSTn = 1'b0;
      tick();
      RSTn = 1'b1;
      repeat (2) tick();
      chk("rst2_fcw", FCW, 85899);

      clr();
      press(K_DN, 10);
      chk("dn1_fcw", FCW, 77309);
      chk("dn1_upd", upd_cnt, 1);
      chk("dn1_lim", lim_cnt, 0);
      clr();
      press(K_STEP, 10);
      chk("step_sel", 32'(Step_Sel), 1);
      chk("step_upd", upd_cnt, 0);
      clr();
      press(K_DN, 10);
      chk("dn2_fcw", FCW, 8590);
      chk("dn2_upd", upd_cnt, 1);
      chk("dn2_lim", lim_cnt, 1);
      clr();
      press(K_DN, 10);
      chk("dn3_fcw", FCW, 8590);
      chk("dn3_upd", upd_cnt, 0);
      chk("dn3_lim", lim_cnt, 1);

      for (int i = 1; i <= 4; i++) begin
         clr();
         press(K_WAVE, 10);
         chk("wave_sel", 32'(Wave_Sel), 32'(i % 4));
         chk("wave_upd", upd_cnt, 1);
      end
      chk("wave_fcw", FCW, 8590);

      clr();
      press(K_UP | K_DN, 10);
      chk("updn_fcw", FCW, 8590);
      chk("updn_upd", upd_cnt, 0);
      chk("updn_lim", lim_cnt, 0);
      clr();
      press(K_UP | K_WAVE, 10);
      chk("upwv_fcw", FCW, 94490);
      chk("upwv_wave", 32'(Wave_Sel), 1);
      chk("upwv_upd", upd_cnt, 1);
      clr();
      press(K_DN | K_STEP, 10);
      chk("dnst_fcw", FCW, 8590);
      chk("dnst_step", 32'(Step_Sel), 2);
      chk("dnst_upd", upd_cnt, 1);
      chk("dnst_lim", lim_cnt, 0);

      keys_n = ~K_UP;
      repeat (30) tick();
      RSTn = 1'b0;
      #1;
      chk("mid_fcw", FCW, 85899);
      chk("mid_wave", 32'(Wave_Sel), 0);
      chk("mid_step", 32'(Step_Sel), 0);
      chk("mid_upd", 32'(Cfg_Update), 0);
      chk("mid_lim", 32'(Limit_Hit), 0);
      repeat (3) tick();
      RSTn = 1'b1;
      n = 0;
      while (!Cfg_Update && n < 20) begin
         tick();
         n++;
      end
      chk("held_lat", n, 8);
      chk("held_fcw", FCW, 94489);
      keys_n = 4'hF;
      repeat (12) tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
